// File: rtl/calc_pkg.sv
// Shared types and key decoding for the calculator input stage.
// The keypad scanner uses it to turn a latched row/column into a key class and value.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;

  typedef enum logic [2:0] {SCAN, DEBOUNCE, EMIT, HELD, RELEASE_DB} scan_state_t;

  typedef enum logic [2:0] {KEY_DIGIT, KEY_OP, KEY_EQ, KEY_CLR, KEY_NEG} key_class_t;

  typedef struct packed {
    key_class_t cls;
    logic [3:0] value;
  } key_info_t;

  // True when exactly one bit of an active-high vector is set.
  function automatic logic exactly_one(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] row_low);
    logic [1:0] idx;
    case (row_low)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Rows 0-2 hold digits 1-9 with an operator in column 3; row 3 is C 0 = +/-.
  function automatic key_info_t decode_key(input logic [1:0] row, input logic [1:0] col);
    key_info_t k;
    k.cls   = KEY_DIGIT;
    k.value = 4'd0;
    if (row == 2'd3) begin
      case (col)
        2'd0:    k.cls = KEY_CLR;
        2'd1:    k.cls = KEY_DIGIT;
        2'd2:    k.cls = KEY_EQ;
        default: k.cls = KEY_NEG;
      endcase
    end else if (col == 2'd3) begin
      k.cls = KEY_OP;
      case (row)
        2'd0:    k.value = {1'b0, OP_ADD};
        2'd1:    k.value = {1'b0, OP_SUB};
        default: k.value = {1'b0, OP_MUL};
      endcase
    end else begin
      k.value = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return k;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous inputs; resets to all ones so an
// idle pulled-up bus reads as inactive.
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives columns in turn, debounces press and
// release, and emits one registered strobe per physical key press.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       digit_strobe,
  output logic [3:0] digit,
  output logic       op_strobe,
  output logic [2:0] op,
  output logic       equal_strobe,
  output logic       clear_strobe,
  output logic       neg_strobe,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0] row_s;

  sync2 #(.WIDTH(4)) u_row_sync (
    .clk (clk),
    .rst (nRST),
    .d   (row_n),
    .q   (row_s)
  );

  scan_state_t   state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    row_lat_q, row_lat_d;
  logic          digit_strobe_q, digit_strobe_d;
  logic          op_strobe_q, op_strobe_d;
  logic          equal_strobe_q, equal_strobe_d;
  logic          clear_strobe_q, clear_strobe_d;
  logic          neg_strobe_q, neg_strobe_d;
  logic [3:0]    digit_q, digit_d;
  logic [2:0]    op_q, op_d;
  logic          key_held_q, key_held_d;
  key_info_t     key;

  always_comb begin
    key            = decode_key(row_index(~row_lat_q), col_q);
    state_d        = state_q;
    dwell_d        = dwell_q;
    cnt_d          = cnt_q;
    col_d          = col_q;
    row_lat_d      = row_lat_q;
    digit_strobe_d = 1'b0;
    op_strobe_d    = 1'b0;
    equal_strobe_d = 1'b0;
    clear_strobe_d = 1'b0;
    neg_strobe_d   = 1'b0;
    digit_d        = digit_q;
    op_d           = op_q;
    key_held_d     = key_held_q;

    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (exactly_one(~row_s)) begin
            row_lat_d = row_s;
            cnt_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (row_s != row_lat_q) begin
          dwell_d = '0;
          state_d = SCAN;
        end else if (cnt_q == CNT_LAST) begin
          // Strobes are registered here so they are high exactly while in EMIT.
          state_d    = EMIT;
          key_held_d = 1'b1;
          case (key.cls)
            KEY_DIGIT: begin
              digit_strobe_d = 1'b1;
              digit_d        = key.value;
            end
            KEY_OP: begin
              op_strobe_d = 1'b1;
              op_d        = key.value[2:0];
            end
            KEY_EQ:  equal_strobe_d = 1'b1;
            KEY_CLR: clear_strobe_d = 1'b1;
            default: neg_strobe_d   = 1'b1;
          endcase
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      EMIT: state_d = HELD;
      HELD: begin
        if (&row_s) begin
          cnt_d   = '0;
          state_d = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (!(&row_s)) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          key_held_d = 1'b0;
          col_d      = 2'd0;
          dwell_d    = '0;
          state_d    = SCAN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nRST) begin
      state_q        <= SCAN;
      dwell_q        <= '0;
      cnt_q          <= '0;
      col_q          <= 2'd0;
      row_lat_q      <= 4'hF;
      digit_strobe_q <= 1'b0;
      op_strobe_q    <= 1'b0;
      equal_strobe_q <= 1'b0;
      clear_strobe_q <= 1'b0;
      neg_strobe_q   <= 1'b0;
      digit_q        <= 4'd0;
      op_q           <= 3'd0;
      key_held_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      dwell_q        <= dwell_d;
      cnt_q          <= cnt_d;
      col_q          <= col_d;
      row_lat_q      <= row_lat_d;
      digit_strobe_q <= digit_strobe_d;
      op_strobe_q    <= op_strobe_d;
      equal_strobe_q <= equal_strobe_d;
      clear_strobe_q <= clear_strobe_d;
      neg_strobe_q   <= neg_strobe_d;
      digit_q        <= digit_d;
      op_q           <= op_d;
      key_held_q     <= key_held_d;
    end
  end

  assign col_n        = ~(4'b0001 << col_q);
  assign digit_strobe = digit_strobe_q;
  assign op_strobe    = op_strobe_q;
  assign equal_strobe = equal_strobe_q;
  assign clear_strobe = clear_strobe_q;
  assign neg_strobe   = neg_strobe_q;
  assign digit        = digit_q;
  assign op           = op_q;
  assign key_held     = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a behavioural keypad drives the rows and every
// strobe is matched against the printed key legend and press/release timing.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 8;

  logic       clk = 1'b0;
  logic       nRST;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       digit_strobe, op_strobe, equal_strobe, clear_strobe, neg_strobe;
  logic [3:0] digit;
  logic [2:0] op;
  logic       key_held;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .nRST         (nRST),
    .row_n        (row_n),
    .col_n        (col_n),
    .digit_strobe (digit_strobe),
    .digit        (digit),
    .op_strobe    (op_strobe),
    .op           (op),
    .equal_strobe (equal_strobe),
    .clear_strobe (clear_strobe),
    .neg_strobe   (neg_strobe),
    .key_held     (key_held)
  );

  // Physical keypad: a pressed switch pulls its row low while its column is driven.
  bit pressed [4][4];

  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !col_n[c]) row_n[r] = 1'b0;
  end

  string keymap [4] = '{"123+", "456-", "789*", "C0=N"};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    byte  kind;
    int   at;
    logic held;
  } ev_t;
  ev_t obs [$];

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Every strobe is turned into the legend character the user would see.
  always @(negedge clk) begin : monitor
    int  n;
    byte k;
    n = int'(digit_strobe) + int'(op_strobe) + int'(equal_strobe)
      + int'(clear_strobe) + int'(neg_strobe);
    if (n != 0) begin
      if (n != 1) checkOutput("one_strobe", n, 1);
      k = "?";
      if (digit_strobe) k = byte'(8'd48 + {4'd0, digit});
      else if (op_strobe) begin
        case (op)
          3'b001:  k = "+";
          3'b010:  k = "-";
          3'b011:  k = "*";
          default: k = "?";
        endcase
      end
      else if (equal_strobe) k = "=";
      else if (clear_strobe) k = "C";
      else if (neg_strobe)   k = "N";
      obs.push_back('{k, cyc, key_held});
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Optional bounce, stable hold, optional second key late in the hold, clean release.
  task automatic applyStimulus(input int r, input int c, input int bounces,
                               input int hold, input int extra);
    int    t0, lat;
    byte   exp_key;
    string row_str;
    row_str = keymap[r];
    exp_key = row_str[c];
    obs.delete();
    for (int b = 0; b < bounces; b++) begin
      pressed[r][c] = 1'b1;
      waitCycles(3);
      pressed[r][c] = 1'b0;
      waitCycles(3);
    end
    pressed[r][c] = 1'b1;
    t0 = cyc;
    if (extra >= 0) begin
      waitCycles(hold - 10);
      pressed[extra / 4][extra % 4] = 1'b1;
      waitCycles(10);
      pressed[extra / 4][extra % 4] = 1'b0;
    end else begin
      waitCycles(hold);
    end
    pressed[r][c] = 1'b0;
    waitCycles(DB + 2);
    checkOutput("held_before_release_done", int'(key_held), 1);
    waitCycles(1);
    checkOutput("held_after_release_done", int'(key_held), 0);
    checkOutput("col_after_release", int'(col_n), 4'b1110);
    waitCycles(4);
    checkOutput($sformatf("events_key_%c", exp_key), obs.size(), 1);
    if (obs.size() > 0) begin
      checkOutput("key_value", int'(obs[0].kind), int'(exp_key));
      lat = obs[0].at - t0;
      checkOutput($sformatf("latency_%0d_ok", lat),
                  int'(lat >= DB + 3 && lat <= 4 * SCAN_DIV + DB + 5), 1);
      checkOutput("held_at_strobe", int'(obs[0].held), 1);
    end
  endtask

  initial begin
    int         idx, k;
    logic [3:0] seen, prev;
    bit         found;

    nRST = 1'b1;
    waitCycles(3);
    checkOutput("rst_col", int'(col_n), 4'b1110);
    checkOutput("rst_held", int'(key_held), 0);
    checkOutput("rst_digit", int'(digit), 0);
    checkOutput("rst_op", int'(op), 0);
    checkOutput("rst_strobes", int'({digit_strobe, op_strobe, equal_strobe,
                                     clear_strobe, neg_strobe}), 0);
    nRST = 1'b0;
    obs.delete();

    for (k = 1; k <= 40; k++) begin
      waitCycles(1);
      idx = (k / SCAN_DIV) % 4;
      checkOutput($sformatf("idle_col_%0d", k), int'(col_n), int'(4'hF ^ (4'h1 << idx)));
    end
    checkOutput("idle_no_strobe", obs.size(), 0);

    $display("[TB] directed presses");
    applyStimulus(1, 2, 0, 40, -1);
    applyStimulus(0, 3, 0, 40, -1);
    applyStimulus(3, 2, 0, 40, -1);
    applyStimulus(2, 1, 2, 40, -1);

    // Two rows low on one column must be rejected while scanning keeps going.
    obs.delete();
    pressed[0][0] = 1'b1;
    pressed[1][0] = 1'b1;
    seen = 4'h0;
    for (int i = 0; i < 40; i++) begin
      waitCycles(1);
      seen |= ~col_n;
    end
    checkOutput("two_rows_scan_all_cols", int'(seen), 4'hF);
    checkOutput("two_rows_no_strobe", obs.size(), 0);
    pressed[0][0] = 1'b0;
    pressed[1][0] = 1'b0;
    waitCycles(20);

    applyStimulus(3, 0, 0, 50, 1);

    // Reset while the +/- key is being debounced.
    found = 1'b0;
    prev  = col_n;
    for (int i = 0; i < 40 && !found; i++) begin
      waitCycles(1);
      if (col_n == 4'b0111 && prev != 4'b0111) found = 1'b1;
      prev = col_n;
    end
    checkOutput("find_col3", int'(found), 1);
    obs.delete();
    pressed[3][3] = 1'b1;
    waitCycles(6);
    nRST = 1'b1;
    waitCycles(1);
    nRST = 1'b0;
    checkOutput("mid_rst_col", int'(col_n), 4'b1110);
    checkOutput("mid_rst_held", int'(key_held), 0);
    pressed[3][3] = 1'b0;
    waitCycles(40);
    checkOutput("mid_rst_no_strobe", obs.size(), 0);
    applyStimulus(3, 3, 0, 45, -1);

    $display("[TB] random presses");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), 40 + int'($urandom_range(0, 15)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream input stage of the 16-bit signed calculator. Scans a 4x4 matrix keypad, synchronizes and debounces the rows, and decodes each press.
- Emits exactly one single-cycle strobe per physical press: digit, operator, equal, clear or negate.
- Its outputs drive the calculator controller's keypad, operator and equal inputs directly.

Parameters:
- SCAN_DIV, 1000: clk cycles each column stays driven while scanning (>=2).
- DEBOUNCE_CYCLES, 200000: consecutive stable cycles required for both press and release (>=2).

Ports:
- clk  in  1  system clock.
- nRST  in  1  reset, synchronous and active-high. The name is kept for codebase consistency; nRST=1 at a clk edge resets the block.
- row_n  in  4  keypad rows, active-low, asynchronous to clk (external pull-ups).
- col_n  out  4  column drive, active-low one-hot.
- digit_strobe  out  1  one-cycle pulse: a digit key was pressed.
- digit  out  4  digit value 0-9; meaningful only with digit_strobe; holds last value otherwise.
- op_strobe  out  1  one-cycle pulse: an operator key was pressed.
- op  out  3  operator code: 3'b001 add, 3'b010 sub, 3'b011 mul; holds last value.
- equal_strobe  out  1  one-cycle pulse: the '=' key was pressed.
- clear_strobe  out  1  one-cycle pulse: the 'C' key was pressed.
- neg_strobe  out  1  one-cycle pulse: the '+/-' key was pressed.
- key_held  out  1  high from the strobe cycle until release debounce completes.

Behaviour:
- Key map, rows r0-r3 by columns c0-c3:
  - r0: 1 2 3 +
  - r1: 4 5 6 -
  - r2: 7 8 9 *
  - r3: C 0 = +/-
- Reset values (nRST high, takes effect at the next clk edge, from any state):
  - state SCAN; col_n=4'b1110; synchronizer flops=4'b1111; all counters 0.
  - all strobes 0; digit=0; op=0; key_held=0.
  - A press in progress is discarded and no strobe is emitted for it.
- Synchronizer: row_n passes through 2 flops, giving row_s. All decisions use row_s.
- State SCAN:
  - The dwell counter counts 0..SCAN_DIV-1. When it reaches SCAN_DIV-1, row_s is sampled.
  - If exactly one row bit is low: latch row and column, freeze col_n, clear the debounce counter, go to DEBOUNCE.
  - Otherwise (no row low, or more than one): rotate to the next column, c3 wraps to c0, and restart dwell.
- State DEBOUNCE:
  - Each cycle row_s equals the latched pattern, the counter increments.
  - Any mismatch returns to SCAN; dwell restarts on the same column.
  - When the counter reaches DEBOUNCE_CYCLES-1, go to EMIT.
- State EMIT (exactly 1 cycle):
  - Assert the one strobe selected by the latched key.
  - Update digit or op in the same cycle as their strobe.
  - Set key_held=1, then go to HELD.
- State HELD: stay while any row_s bit is low. When all rows are high, clear the counter and go to RELEASE_DB.
- State RELEASE_DB:
  - Count consecutive all-high cycles. Any low row clears the counter and the state stays put; returning to HELD is not required.
  - At DEBOUNCE_CYCLES-1: key_held=0, col_n=4'b1110 (column 0), go to SCAN.
- Strobes:
  - Registered, mutually exclusive; never more than one high in any cycle.
  - Holding a key produces no auto-repeat.
- Latency, from a stable press on the currently driven column to its strobe: 2 (sync) + at most SCAN_DIV (dwell) + DEBOUNCE_CYCLES + 1 cycles.
- A second key pressed while one is held is ignored. Scanning resumes only after full release of all keys.

Decomposition:
- Package calc_pkg:
  - op codes OP_ADD=3'b001, OP_SUB=3'b010, OP_MUL=3'b011;
  - scan_state_t enum {SCAN, DEBOUNCE, EMIT, HELD, RELEASE_DB};
  - key-class enum {KEY_DIGIT, KEY_OP, KEY_EQ, KEY_CLR, KEY_NEG}.
- Sub-module sync2: a parameterised-width 2-flop synchronizer with synchronous active-high reset value 1s, used for row_n.
- Key decode (row,col to class/value) is a function in calc_pkg.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8 unless stated):
- Reset, then idle rows 4'b1111 for 40 cycles -> col_n cycles 1110, 1101, 1011, 0111, 1110 every 4 cycles; no strobes.
- Hold r1 low while c2 is driven, for 30 cycles, then release -> exactly one digit_strobe with digit=6; key_held high until 8 cycles after release; col_n returns to 1110.
- Press r0/c3, then r3/c2 after full release -> op_strobe with op=3'b001, then a separate equal_strobe; never two strobes in the same cycle.
- Bounce r2/c1 low-high-low with 3-cycle periods, then hold stable -> no strobe during bouncing; one digit_strobe with digit=8 after 8 stable cycles.
- r0 and r1 both low on c0 -> no strobe and scanning continues. Separately: hold r3/c0 while a second key is pressed -> single clear_strobe only.
- Assert nRST for 1 cycle during DEBOUNCE of r3/c3 -> no neg_strobe; next edge shows col_n=1110 and key_held=0; a re-press after release yields neg_strobe.
